// File: rtl/morse_keyer_if.sv
// Character handshake between the input/control logic and the Morse keyer.
// The upstream side drives the valid and code signals; the keyer drives ready.
interface morse_keyer_if;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_code,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_code,
    output char_ready
  );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: buffers character codes in a FIFO, encodes them to ITU Morse
// and emits a unit-timed on/off key_out for the downstream buzzer stage.
module morse_keyer #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  morse_keyer_if.slave up,
  output logic         key_out,
  output logic         busy,
  output logic         char_err
);
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] SPACE_CODE = 6'd36;

  typedef enum logic [2:0] {
    IDLE, LOAD, MARK, SPACE, GAP
  } state_t;

  state_t         state;
  logic [5:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [5:0]     cur;
  logic [2:0]     len, sym_idx, units;
  logic [4:0]     pat;
  logic [CW-1:0]  cnt;
  logic [7:0]     ent;
  logic full, empty, accept, bad, push, pop;
  logic timed, tick, expire;

  // {len, pat}; pat bit i is symbol i in send order, 1 = dash
  function automatic logic [7:0] rom(input logic [5:0] c);
    case (c)
      6'd0:  rom = {3'd2, 5'b00010};
      6'd1:  rom = {3'd4, 5'b00001};
      6'd2:  rom = {3'd4, 5'b00101};
      6'd3:  rom = {3'd3, 5'b00001};
      6'd4:  rom = {3'd1, 5'b00000};
      6'd5:  rom = {3'd4, 5'b00100};
      6'd6:  rom = {3'd3, 5'b00011};
      6'd7:  rom = {3'd4, 5'b00000};
      6'd8:  rom = {3'd2, 5'b00000};
      6'd9:  rom = {3'd4, 5'b01110};
      6'd10: rom = {3'd3, 5'b00101};
      6'd11: rom = {3'd4, 5'b00010};
      6'd12: rom = {3'd2, 5'b00011};
      6'd13: rom = {3'd2, 5'b00001};
      6'd14: rom = {3'd3, 5'b00111};
      6'd15: rom = {3'd4, 5'b00110};
      6'd16: rom = {3'd4, 5'b01011};
      6'd17: rom = {3'd3, 5'b00010};
      6'd18: rom = {3'd3, 5'b00000};
      6'd19: rom = {3'd1, 5'b00001};
      6'd20: rom = {3'd3, 5'b00100};
      6'd21: rom = {3'd4, 5'b01000};
      6'd22: rom = {3'd3, 5'b00110};
      6'd23: rom = {3'd4, 5'b01001};
      6'd24: rom = {3'd4, 5'b01101};
      6'd25: rom = {3'd4, 5'b00011};
      6'd26: rom = {3'd5, 5'b11111};
      6'd27: rom = {3'd5, 5'b11110};
      6'd28: rom = {3'd5, 5'b11100};
      6'd29: rom = {3'd5, 5'b11000};
      6'd30: rom = {3'd5, 5'b10000};
      6'd31: rom = {3'd5, 5'b00000};
      6'd32: rom = {3'd5, 5'b00001};
      6'd33: rom = {3'd5, 5'b00011};
      6'd34: rom = {3'd5, 5'b00111};
      6'd35: rom = {3'd5, 5'b01111};
      default: rom = 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] dur(input logic dash);
    dur = dash ? 3'd3 : 3'd1;
  endfunction

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign up.char_ready = !full;
  assign accept = up.char_valid & !full;
  assign bad    = (up.char_code > SPACE_CODE);
  assign push   = accept & !bad;
  assign pop    = (state == IDLE) & !empty;
  assign ent    = rom(cur);
  assign timed  = (state == MARK) | (state == SPACE) | (state == GAP);
  assign tick   = (cnt == CW'(UNIT_CYCLES - 1));
  assign expire = timed & tick & (units == 3'd1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up.char_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cur      <= '0;
      len      <= '0;
      pat      <= '0;
      sym_idx  <= '0;
      units    <= '0;
      cnt      <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      char_err <= 1'b0;
    end else begin
      char_err <= accept & bad;
      busy     <= (state != IDLE) | !empty | push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & !pop)      count <= count + 1'b1;
      else if (!push & pop) count <= count - 1'b1;

      if (timed) begin
        if (tick) begin
          cnt   <= '0;
          units <= units - 3'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (!empty) begin
            cur   <= mem[rd_ptr];
            state <= LOAD;
          end
        end
        LOAD: begin
          len     <= ent[7:5];
          pat     <= ent[4:0];
          sym_idx <= '0;
          cnt     <= '0;
          if (cur == SPACE_CODE) begin
            state <= GAP;
            units <= 3'd7;
          end else begin
            state   <= MARK;
            units   <= dur(ent[0]);
            key_out <= 1'b1;
          end
        end
        MARK: begin
          if (expire) begin
            key_out <= 1'b0;
            cnt     <= '0;
            if (sym_idx + 3'd1 < len) begin
              state   <= SPACE;
              units   <= 3'd1;
              sym_idx <= sym_idx + 3'd1;
            end else begin
              state <= GAP;
              units <= 3'd3;
            end
          end
        end
        SPACE: begin
          if (expire) begin
            state   <= MARK;
            cnt     <= '0;
            units   <= dur(pat[sym_idx]);
            key_out <= 1'b1;
          end
        end
        GAP: begin
          if (expire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
